// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, 1-cycle imem latency, skid buffer, redirect flush
package fetch_unit_pkg;
    typedef logic [31:0] insn_t;

    localparam insn_t NOP_INSN = 32'h0000_0013;

    localparam logic [1:0] CAUSE_NONE       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
    localparam logic [1:0] CAUSE_RANGE      = 2'b10;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 512
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_en,
    output logic [31:0] o_imem_pc,
    input  insn_t       i_imem_insn,
    input  logic        i_imem_exception,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output insn_t       o_insn,
    output logic [31:0] o_pc,
    output logic [1:0]  o_exc_cause,
    output logic        o_halted
);

    localparam logic [31:0] LAST_WORD_PC = 32'(IMEM_SIZE - 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;

    // rsp_* describes the fetch whose data is arriving on i_imem_insn this cycle
    logic        rsp_vld;
    logic [31:0] rsp_pc;
    logic [1:0]  rsp_cause;

    logic        skid_vld;
    insn_t       skid_insn;
    logic [31:0] skid_pc;
    logic [1:0]  skid_cause;

    logic [1:0]  issue_cause;
    logic        issue;
    logic        fire;
    insn_t       sel_insn;
    logic [31:0] sel_pc;
    logic [1:0]  sel_cause;

    assign o_imem_pc = pc_q;
    assign o_halted  = (state_q == S_HALT);

    always_comb begin
        issue_cause = CAUSE_NONE;
        if (i_imem_exception || (pc_q[1:0] != 2'b00)) begin
            issue_cause = CAUSE_MISALIGNED;
        end else if (pc_q > LAST_WORD_PC) begin
            issue_cause = CAUSE_RANGE;
        end
    end

    // A new fetch may only issue if its data has a guaranteed landing spot next cycle
    assign issue = (state_q == S_RUN) && i_fetch_en && !i_redirect && !skid_vld
                   && (!rsp_vld || i_ready);

    always_comb begin
        sel_insn  = NOP_INSN;
        sel_pc    = 32'h0;
        sel_cause = CAUSE_NONE;
        if (skid_vld) begin
            sel_insn  = skid_insn;
            sel_pc    = skid_pc;
            sel_cause = skid_cause;
        end else if (rsp_vld) begin
            sel_insn  = i_imem_insn;
            sel_pc    = rsp_pc;
            sel_cause = rsp_cause;
        end
    end

    assign o_valid     = (skid_vld || rsp_vld) && !i_redirect;
    assign fire        = o_valid && i_ready;
    assign o_pc        = sel_pc;
    assign o_exc_cause = sel_cause;
    assign o_insn      = (sel_cause != CAUSE_NONE) ? NOP_INSN : sel_insn;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_fetch_en) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_fetch_en) begin
                    state_d = S_IDLE;
                end else if (issue && (issue_cause != CAUSE_NONE)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (i_redirect) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            rsp_vld    <= 1'b0;
            rsp_pc     <= 32'h0;
            rsp_cause  <= CAUSE_NONE;
            skid_vld   <= 1'b0;
            skid_insn  <= NOP_INSN;
            skid_pc    <= 32'h0;
            skid_cause <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (i_redirect) begin
                pc_q     <= i_redirect_pc;
                rsp_vld  <= 1'b0;
                skid_vld <= 1'b0;
            end else begin
                if (issue) begin
                    pc_q      <= pc_q + 32'd4;
                    rsp_pc    <= pc_q;
                    rsp_cause <= issue_cause;
                end
                if (skid_vld) begin
                    if (fire) begin
                        skid_vld <= 1'b0;
                    end
                end else if (rsp_vld && !fire) begin
                    // memory data is only valid this one cycle, so park it
                    skid_insn  <= i_imem_insn;
                    skid_pc    <= rsp_pc;
                    skid_cause <= rsp_cause;
                    skid_vld   <= 1'b1;
                    rsp_vld    <= 1'b0;
                end else begin
                    rsp_vld <= issue;
                end
            end
        end
    end

endmodule
